// File: rtl/activation_sender.sv
// Initiator of the BAR activation handshake: streams preamble words plus the activation code,
// then waits for bar_enabled, retrying on timeout. All outputs are registered; start-to-valid latency is one cycle.
module activation_sender #(
    parameter logic [31:0] ACTIVATE_CODE = 32'hA5A5_FF00,
    parameter logic [31:0] PREAMBLE_WORD = 32'h0000_0000,
    parameter int unsigned PREAMBLE_LEN  = 2,
    parameter int unsigned ACK_TIMEOUT   = 64,
    parameter int unsigned MAX_ATTEMPTS  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] dma_data,
    output logic        dma_valid,
    input  logic        dma_ready,
    input  logic        bar_enabled,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [3:0]  attempts
);

    localparam int unsigned TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [3:0] PRE_LAST = 4'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
    localparam logic [3:0] MAX_ATT  = 4'(MAX_ATTEMPTS);
    localparam bit HAS_PRE = (PREAMBLE_LEN > 0);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_CODE, S_WAIT_ACK, S_DONE, S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    pre_cnt_q, pre_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    attempts_q, attempts_d;
    logic [31:0]   dma_data_q, dma_data_d;
    logic          dma_valid_q, dma_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic          accept;

    assign accept = dma_valid_q & dma_ready;

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        timer_d    = timer_q;
        attempts_d = attempts_q;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    attempts_d = 4'd0;
                    pre_cnt_d  = 4'd0;
                    timer_d    = '0;
                    if (bar_enabled) state_d = S_DONE;
                    else             state_d = HAS_PRE ? S_PREAMBLE : S_CODE;
                end
            end
            S_PREAMBLE: begin
                if (accept) begin
                    if (pre_cnt_q == PRE_LAST) begin
                        pre_cnt_d = 4'd0;
                        state_d   = S_CODE;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end
                end
            end
            S_CODE: begin
                if (accept) begin
                    if (attempts_q < MAX_ATT) attempts_d = attempts_q + 4'd1;
                    timer_d = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // The acknowledge wins even on the cycle the timer expires.
                if (bar_enabled) begin
                    state_d = S_DONE;
                end else if (timer_q == TMR_LAST) begin
                    if (attempts_q < MAX_ATT) begin
                        pre_cnt_d = 4'd0;
                        state_d   = HAS_PRE ? S_PREAMBLE : S_CODE;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registers line up with state_q.
        dma_valid_d = (state_d == S_PREAMBLE) || (state_d == S_CODE);
        dma_data_d  = (state_d == S_PREAMBLE) ? PREAMBLE_WORD :
                      (state_d == S_CODE)     ? ACTIVATE_CODE : 32'd0;
        busy_d      = dma_valid_d || (state_d == S_WAIT_ACK);
        done_d      = (state_d == S_DONE);
        fail_d      = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pre_cnt_q   <= 4'd0;
            timer_q     <= '0;
            attempts_q  <= 4'd0;
            dma_data_q  <= 32'd0;
            dma_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            timer_q     <= timer_d;
            attempts_q  <= attempts_d;
            dma_data_q  <= dma_data_d;
            dma_valid_q <= dma_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign dma_data  = dma_data_q;
    assign dma_valid = dma_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign attempts  = attempts_q;

endmodule

// File: tb/tb_activation_sender.sv
// Directed bench for activation_sender: a scoreboard of expected DMA words is filled when a
// sequence is started and drained by a negedge monitor as words are accepted.
module tb_activation_sender;

    localparam logic [31:0] CODE = 32'hA5A5_FF00;
    localparam logic [31:0] PRE  = 32'h0000_0000;

    logic        clk, rst, start, dma_ready, bar_enabled;
    logic [31:0] dma_data;
    logic        dma_valid, busy, done, fail;
    logic [3:0]  attempts;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int word_cnt = 0;
    int code_cnt = 0;
    int code_cyc[$];
    logic [31:0] sb_q[$];

    activation_sender dut (
        .clk(clk), .rst(rst), .start(start),
        .dma_data(dma_data), .dma_valid(dma_valid), .dma_ready(dma_ready),
        .bar_enabled(bar_enabled), .busy(busy), .done(done), .fail(fail),
        .attempts(attempts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq();
        sb_q.push_back(PRE);
        sb_q.push_back(PRE);
        sb_q.push_back(CODE);
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(done || fail) && n < budget) begin
            tick();
            n++;
        end
        check("wait_end_in_budget", 32'(done | fail), 32'd1);
    endtask

    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat   = 32'd0;
    logic [31:0] exp_w;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", 32'(dma_valid), 32'd1);
                check("hold_dat", dma_data, prev_dat);
            end
            if (!dma_valid) check("idle_dat_zero", dma_data, 32'd0);
            check("done_fail_excl", 32'(done & fail), 32'd0);
            if (dma_valid && dma_ready) begin
                word_cnt++;
                if (dma_data == CODE) begin
                    code_cnt++;
                    code_cyc.push_back(cyc);
                end
                check("sb_not_empty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    exp_w = sb_q.pop_front();
                    check("sb_word", dma_data, exp_w);
                end
            end
            prev_stall = dma_valid && !dma_ready;
            prev_dat   = dma_data;
        end
    end

    initial begin
        int w0, c0;
        logic [3:0] pat;
        pat = 4'b1001;
        rst = 1'b1; start = 1'b0; dma_ready = 1'b1; bar_enabled = 1'b0;
        #1;
        check("rst_dat", dma_data, 32'd0);
        check("rst_vld", 32'(dma_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_att", 32'(attempts), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic activation: two preambles and the code back to back, ack three cycles later.
        push_seq();
        w0 = word_cnt;
        start = 1'b1; tick(); start = 1'b0;
        check("t1_vld", 32'(dma_valid), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_dat", dma_data, PRE);
        tick(); tick(); tick();
        check("t1_words_consecutive", 32'(word_cnt - w0), 32'd3);
        check("t1_att", 32'(attempts), 32'd1);
        check("t1_wait_vld", 32'(dma_valid), 32'd0);
        check("t1_wait_busy", 32'(busy), 32'd1);
        tick(); tick();
        bar_enabled = 1'b1;
        wait_end(10);
        check("t1_done", 32'(done), 32'd1);
        check("t1_fail", 32'(fail), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);
        check("t1_att_final", 32'(attempts), 32'd1);
        bar_enabled = 1'b0;
        tick();
        check("t1_done_sticky", 32'(done), 32'd1);

        // Backpressure: ready pattern 1,0,0,1 repeating.
        push_seq();
        w0 = word_cnt; c0 = code_cnt;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            dma_ready = pat[i % 4];
            tick();
            if (busy && !dma_valid) break;
        end
        dma_ready = 1'b1;
        check("t2_in_wait", 32'(busy && !dma_valid), 32'd1);
        check("t2_words", 32'(word_cnt - w0), 32'd3);
        check("t2_codes", 32'(code_cnt - c0), 32'd1);
        bar_enabled = 1'b1;
        wait_end(10);
        check("t2_done", 32'(done), 32'd1);
        bar_enabled = 1'b0;

        // No acknowledge: three attempts spaced by 64 wait cycles plus a preamble, then fail.
        push_seq(); push_seq(); push_seq();
        c0 = code_cyc.size();
        start = 1'b1; tick(); start = 1'b0;
        wait_end(400);
        check("t3_fail", 32'(fail), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_att", 32'(attempts), 32'd3);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_vld", 32'(dma_valid), 32'd0);
        check("t3_codes", 32'(code_cyc.size() - c0), 32'd3);
        if (code_cyc.size() >= c0 + 3) begin
            check("t3_gap1", 32'(code_cyc[c0+1] - code_cyc[c0]), 32'd67);
            check("t3_gap2", 32'(code_cyc[c0+2] - code_cyc[c0+1]), 32'd67);
        end

        // Start from FAIL with the device already enabled: straight to DONE, nothing sent.
        bar_enabled = 1'b1;
        w0 = word_cnt;
        start = 1'b1; tick(); start = 1'b0;
        check("t4_done", 32'(done), 32'd1);
        check("t4_fail_clr", 32'(fail), 32'd0);
        check("t4_att", 32'(attempts), 32'd0);
        check("t4_vld", 32'(dma_valid), 32'd0);
        tick();
        check("t4_no_words", 32'(word_cnt - w0), 32'd0);
        bar_enabled = 1'b0;

        // Reset while the code word is stalled.
        push_seq();
        start = 1'b1; tick(); start = 1'b0;
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_att_clr", 32'(attempts), 32'd0);
        tick(); tick();
        dma_ready = 1'b0;
        check("t5_code_dat", dma_data, CODE);
        tick(); tick();
        check("t5_code_held", dma_data, CODE);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_dat", dma_data, 32'd0);
        check("t5_rst_vld", 32'(dma_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_att", 32'(attempts), 32'd0);
        sb_q.delete();
        tick(); tick();
        rst = 1'b0;
        dma_ready = 1'b1;
        w0 = word_cnt;
        repeat (10) tick();
        check("t5_quiet_words", 32'(word_cnt - w0), 32'd0);
        check("t5_quiet_vld", 32'(dma_valid), 32'd0);

        // Ack on the timer-expiry cycle, with a start pulse ignored during WAIT_ACK.
        push_seq();
        c0 = code_cnt;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (code_cnt != c0) break;
        end
        check("t6_code_seen", 32'(code_cnt - c0), 32'd1);
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
        check("t6_start_ign_vld", 32'(dma_valid), 32'd0);
        check("t6_start_ign_busy", 32'(busy), 32'd1);
        check("t6_start_ign_att", 32'(attempts), 32'd1);
        repeat (52) tick();
        bar_enabled = 1'b1;
        w0 = word_cnt;
        tick();
        check("t6_done", 32'(done), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_vld", 32'(dma_valid), 32'd0);
        check("t6_att", 32'(attempts), 32'd1);
        repeat (5) tick();
        check("t6_no_retry", 32'(word_cnt - w0), 32'd0);
        bar_enabled = 1'b0;

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
